dco_slew_ctrl: RTL and testbench

- Sequences updates of the ring-oscillator frequency select driven by the ADPLL loop.
- Accepts signed DCO control codes through a valid/ready handshake and computes the target select as BIAS minus the code, saturated to the select range.
- Walks f_sel_o to the target one LSB at a time, with a settle interval between steps, so the RO mux never jumps by more than one tap.
- Sits between the loop filter output and the ring-oscillator select input.

---
 rtl/dco_slew_ctrl.sv | 144 ++++++++++++++
 tb/tb_dco_slew_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dco_slew_ctrl.sv
// DCO frequency-select slew controller: accepts signed control codes, clamps
// BIAS - code into the RO select range and walks f_sel_o there one tap at a time.
module dco_slew_ctrl #(
  parameter int RO_WIDTH      = 5,
  parameter int CC_WIDTH      = 5,
  parameter int BIAS          = 16,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable_i,
  input  logic                       cc_valid_i,
  output logic                       cc_ready_o,
  input  logic signed [CC_WIDTH-1:0] dco_cc_i,
  output logic        [RO_WIDTH-1:0] f_sel_o,
  output logic                       upd_o,
  output logic                       busy_o,
  output logic                       sat_o
);

  localparam int TW    = RO_WIDTH + 2;
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic signed [TW-1:0]   BIAS_S      = TW'(BIAS);
  localparam logic signed [TW-1:0]   SEL_MAX     = TW'((1 << RO_WIDTH) - 1);
  localparam logic [RO_WIDTH-1:0]    BIAS_SEL    = RO_WIDTH'(BIAS);
  localparam logic [RO_WIDTH-1:0]    SEL_MAX_U   = RO_WIDTH'((1 << RO_WIDTH) - 1);
  localparam logic [CNT_W-1:0]       SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    SETTLE
  } state_t;

  state_t              state_q, state_d;
  logic [RO_WIDTH-1:0] f_sel_q, f_sel_d;
  logic [RO_WIDTH-1:0] target_q, target_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                upd_q, upd_d;
  logic                sat_q, sat_d;
  logic                alive_q;

  logic signed [TW-1:0] cc_ext;
  logic signed [TW-1:0] t_raw;
  logic [RO_WIDTH-1:0]  t_clamp;
  logic                 t_sat;
  logic [RO_WIDTH-1:0]  f_sel_step;
  logic                 xfer;

  assign cc_ext = {{(TW - CC_WIDTH){dco_cc_i[CC_WIDTH-1]}}, dco_cc_i};
  assign t_raw  = BIAS_S - cc_ext;

  // NOTE: every combinational output gets a default before any branch, so no path can infer a latch.
  always_comb begin
    t_clamp = t_raw[RO_WIDTH-1:0];
    t_sat   = 1'b0;
    if (t_raw[TW-1]) begin
      t_clamp = '0;
      t_sat   = 1'b1;
    end else if (t_raw > SEL_MAX) begin
      t_clamp = SEL_MAX_U;
      t_sat   = 1'b1;
    end
  end

  // Ready stays low until the first clock after reset, then follows state and enable.
  assign cc_ready_o = alive_q && enable_i && (state_q == IDLE);
  assign xfer       = cc_valid_i && cc_ready_o;
  assign f_sel_step = (target_q > f_sel_q) ? f_sel_q + 1'b1 : f_sel_q - 1'b1;

  always_comb begin
    state_d  = state_q;
    f_sel_d  = f_sel_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    upd_d    = 1'b0;
    sat_d    = sat_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          target_d = t_clamp;
          sat_d    = t_sat;
          if (t_clamp != f_sel_q) state_d = STEP;
        end
      end
      STEP: begin
        if (!enable_i) begin
          state_d  = IDLE;
          target_d = f_sel_q;
          cnt_d    = '0;
        end else begin
          f_sel_d = f_sel_step;
          upd_d   = 1'b1;
          if (SETTLE_CYCLES == 0) begin
            if (f_sel_step == target_q) state_d = IDLE;
          end else begin
            state_d = SETTLE;
            cnt_d   = SETTLE_LOAD;
          end
        end
      end
      SETTLE: begin
        if (!enable_i) begin
          state_d  = IDLE;
          target_d = f_sel_q;
          cnt_d    = '0;
        end else if (cnt_q == '0) begin
          state_d = (f_sel_q == target_q) ? IDLE : STEP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      f_sel_q  <= BIAS_SEL;
      target_q <= BIAS_SEL;
      cnt_q    <= '0;
      upd_q    <= 1'b0;
      sat_q    <= 1'b0;
      alive_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      f_sel_q  <= f_sel_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      upd_q    <= upd_d;
      sat_q    <= sat_d;
      alive_q  <= 1'b1;
    end
  end

  assign f_sel_o = f_sel_q;
  assign upd_o   = upd_q;
  assign sat_o   = sat_q;
  assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_dco_slew_ctrl.sv
// Bench for dco_slew_ctrl: a timing-arithmetic model checked every cycle,
// plus literal expectations from hand-worked scenarios.
module tb_dco_slew_ctrl;

  localparam int S       = 3;
  localparam int BIAS    = 16;
  localparam int SEL_MAX = 31;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b1;
  logic              valid = 1'b0;
  logic signed [4:0] cc = '0;
  logic              ready, upd, busy, sat;
  logic [4:0]        f_sel;

  logic              en0 = 1'b1;
  logic              valid0 = 1'b0;
  logic signed [4:0] cc0 = '0;
  logic              ready0, upd0, busy0, sat0;
  logic [4:0]        f_sel0;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dco_slew_ctrl #(.RO_WIDTH(5), .CC_WIDTH(5), .BIAS(BIAS), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .cc_valid_i(valid), .cc_ready_o(ready),
    .dco_cc_i(cc), .f_sel_o(f_sel), .upd_o(upd), .busy_o(busy), .sat_o(sat)
  );

  dco_slew_ctrl #(.RO_WIDTH(5), .CC_WIDTH(5), .BIAS(BIAS), .SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable_i(en0), .cc_valid_i(valid0), .cc_ready_o(ready0),
    .dco_cc_i(cc0), .f_sel_o(f_sel0), .upd_o(upd0), .busy_o(busy0), .sat_o(sat0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a move is an acceptance edge plus a step count; step k lands (k-1)*(S+1)+1
  // edges after acceptance and the move is busy for steps*(S+1) edges.
  int m_sel, m_edge, m_acc, m_steps, m_dir, m_t, m_e;
  bit m_sat, m_upd, m_active, m_alive;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sel = BIAS; m_sat = 0; m_upd = 0; m_active = 0; m_alive = 0; m_edge = 0;
    end else begin
      m_edge++;
      m_upd = 0;
      if (m_active) begin
        if (!enable) m_active = 0;
        else begin
          m_e = m_edge - m_acc;
          if (m_e >= 1 && (m_e - 1) % (S + 1) == 0 && (m_e - 1) / (S + 1) < m_steps) begin
            m_sel = m_sel + m_dir;
            m_upd = 1;
          end
          if (m_e >= m_steps * (S + 1)) m_active = 0;
        end
      end else if (m_alive && enable && valid) begin
        m_t = BIAS - int'(cc);
        m_sat = (m_t < 0) || (m_t > SEL_MAX);
        if (m_t < 0) m_t = 0;
        if (m_t > SEL_MAX) m_t = SEL_MAX;
        if (m_t != m_sel) begin
          m_active = 1;
          m_acc    = m_edge;
          m_dir    = (m_t > m_sel) ? 1 : -1;
          m_steps  = (m_t > m_sel) ? m_t - m_sel : m_sel - m_t;
        end
      end
      m_alive = 1;
    end
  end

  always @(negedge clk) begin
    check("f_sel", f_sel, m_sel);
    check("upd", upd, m_upd);
    check("busy", busy, m_active);
    check("ready", ready, m_alive && enable && !m_active);
    check("sat", sat, m_sat);
  end

  // Stimulus runs at negedge+1 so inputs never change at an active edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic send(input int code);
    int k = 0;
    valid = 1'b1;
    cc = 5'(code);
    while (!ready && k < 200) begin
      tick(1);
      k++;
    end
    if (k >= 200) begin
      n_assert++; n_fail++;
      $display("FAIL send_timeout: ready stayed 0, expected 1");
    end
    @(posedge clk);
    #1 valid = 1'b0;
    tick(1);
  endtask

  task automatic wait_idle(input string name, output int upds);
    int k = 0;
    upds = 0;
    while (busy && k < 1000) begin
      tick(1);
      if (upd) upds++;
      k++;
    end
    if (k >= 1000) begin
      n_assert++; n_fail++;
      $display("FAIL %s_timeout: busy stayed 1, expected 0", name);
    end
  endtask

  int ups, bcnt, k;

  initial begin
    // 1: reset defaults, ready on the first clock after release
    tick(2);
    check("rst_f_sel", f_sel, 16);
    check("rst_ready", ready, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick(1);
    check("ready_after_rst", ready, 1);

    // 2: code 3 -> 15, 14, 13 spaced 4 clocks, busy 12 clocks
    send(3);
    bcnt = 0; ups = 0;
    for (int i = 0; i <= 12; i++) begin
      if (i > 0) tick(1);
      if (busy) bcnt++;
      if (upd) ups++;
      if (i == 1) check("t2_step1", f_sel, 15);
      if (i == 5) check("t2_step2", f_sel, 14);
      if (i == 9) check("t2_step3", f_sel, 13);
    end
    check("t2_busy_clocks", bcnt, 12);
    check("t2_upd_pulses", ups, 3);
    check("t2_sat", sat, 0);
    check("t2_ready", ready, 1);

    send(0);
    wait_idle("back16", ups);
    check("back16_f_sel", f_sel, 16);

    // 4: code 0 at 16 is a no-op; a second code is taken on the very next edge
    tick(1);
    valid = 1'b1; cc = 5'sd0;
    check("t4_ready0", ready, 1);
    @(posedge clk);
    #1 cc = -5'sd16;
    tick(1);
    check("t4_busy_noop", busy, 0);
    check("t4_upd_noop", upd, 0);
    check("t4_ready_b2b", ready, 1);
    @(posedge clk);
    #1 valid = 1'b0;
    tick(1);
    check("t4_second_taken", busy, 1);

    // 3: clamp high then long walk down
    wait_idle("t3_up", ups);
    check("t3_f_sel_max", f_sel, 31);
    check("t3_sat_hi", sat, 1);
    check("t3_upd_up", ups, 15);
    tick(1);
    send(15);
    check("t3_sat_clear", sat, 0);
    wait_idle("t3_down", ups);
    check("t3_f_sel_1", f_sel, 1);
    check("t3_upd_down", ups, 30);
    tick(1);
    send(0);
    wait_idle("back16b", ups);

    // 5: abort by enable drop at 14
    tick(1);
    send(6);
    k = 0;
    while (f_sel != 14 && k < 100) begin tick(1); k++; end
    check("t5_reached14", f_sel, 14);
    enable = 1'b0;
    tick(1);
    check("t5_hold14", f_sel, 14);
    check("t5_busy", busy, 0);
    check("t5_ready", ready, 0);
    tick(2);
    check("t5_still14", f_sel, 14);
    enable = 1'b1;
    #1;
    check("t5_reenable_ready", ready, 1);
    check("t5_reenable_f_sel", f_sel, 14);

    // 6: async reset mid-settle at 12
    tick(1);
    send(6);
    k = 0;
    while (f_sel != 12 && k < 100) begin tick(1); k++; end
    check("t6_reached12", f_sel, 12);
    tick(1);
    check("t6_in_settle", busy, 1);
    rst_n = 1'b0;
    #1;
    check("t6_async_f_sel", f_sel, 16);
    check("t6_async_busy", busy, 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check("t6_ready_after", ready, 1);

    // 6b: SETTLE_CYCLES=0 instance steps on consecutive clocks
    valid0 = 1'b1; cc0 = 5'sd2;
    check("z_ready", ready0, 1);
    @(posedge clk);
    #1 valid0 = 1'b0;
    tick(1);
    check("z_f_sel_e0", f_sel0, 16);
    check("z_busy_e0", busy0, 1);
    tick(1);
    check("z_f_sel_e1", f_sel0, 15);
    check("z_upd_e1", upd0, 1);
    tick(1);
    check("z_f_sel_e2", f_sel0, 14);
    check("z_upd_e2", upd0, 1);
    check("z_busy_e2", busy0, 0);
    tick(1);
    check("z_upd_e3", upd0, 0);
    check("z_sat", sat0, 0);

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
